// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states
// and the busy-counter width.
package mdu_pkg;

   localparam int CNT_W = 4;

   typedef enum logic [2:0] {
      OP_NONE  = 3'd0,
      OP_MULT  = 3'd1,
      OP_MULTU = 3'd2,
      OP_DIV   = 3'd3,
      OP_DIVU  = 3'd4,
      OP_MTHI  = 3'd5,
      OP_MTLO  = 3'd6,
      OP_RSVD  = 3'd7
   } mdu_op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } mdu_state_e;

   function automatic logic is_mult(mdu_op_e op);
      return (op == OP_MULT) || (op == OP_MULTU);
   endfunction

   function automatic logic is_div(mdu_op_e op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/mdu_if.sv
// Issue/result bus between the pipeline (master) and the MDU (slave).
// start+op are sampled only at edges where busy was low beforehand; while busy
// is high any start is dropped, and HI/LO always show architectural values.
interface mdu_if;
   logic        start;
   logic [2:0]  op;
   logic [31:0] A;
   logic [31:0] B;
   logic [31:0] pc;
   logic        busy;
   logic [31:0] HI;
   logic [31:0] LO;

   modport master (output start, op, A, B, pc, input busy, HI, LO);
   modport slave  (input start, op, A, B, pc, output busy, HI, LO);
endinterface

// File: rtl/mdu_calc.sv
// Combinational 64-bit product / quotient / remainder from latched operands.
// wr_o is low for a zero divisor, so HI/LO keep their old values.
module mdu_calc
   import mdu_pkg::*;
(
   input  mdu_op_e     op_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o,
   output logic        wr_o
);

   logic signed [63:0] prod_s;
   logic        [63:0] prod_u;
   logic        [31:0] b_safe;
   logic               div_ovf;

   assign prod_s  = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
   assign prod_u  = {32'd0, a_i} * {32'd0, b_i};
   assign b_safe  = (b_i == 32'd0) ? 32'd1 : b_i;
   // The single signed overflow case has a defined MIPS result; pin it here.
   assign div_ovf = (a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF);

   always_comb begin
      hi_o = '0;
      lo_o = '0;
      wr_o = 1'b0;
      case (op_i)
         OP_MULT: begin
            {hi_o, lo_o} = prod_s;
            wr_o         = 1'b1;
         end
         OP_MULTU: begin
            {hi_o, lo_o} = prod_u;
            wr_o         = 1'b1;
         end
         OP_DIV: begin
            wr_o = (b_i != 32'd0);
            if (div_ovf) begin
               lo_o = 32'h8000_0000;
               hi_o = 32'd0;
            end else begin
               lo_o = $signed(a_i) / $signed(b_safe);
               hi_o = $signed(a_i) % $signed(b_safe);
            end
         end
         OP_DIVU: begin
            wr_o = (b_i != 32'd0);
            lo_o = a_i / b_safe;
            hi_o = a_i % b_safe;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mdu.sv
// MIPS-style HI/LO multiply-divide unit: IDLE/RUN FSM, busy counter, HI/LO.
// Optional MDU_DISPLAY_EN prints every HI/LO write with the issuing pc.
module mdu
   import mdu_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic       clk,
   input  logic       reset,
   mdu_if.slave       bus,
   output mdu_state_e dbg_state_o
);

   mdu_state_e       state_q;
   logic [CNT_W-1:0] cnt_q;
   mdu_op_e          op_q;
   logic [31:0]      a_q, b_q;
   logic [31:0]      hi_q, lo_q, hi_d, lo_d;
   logic [31:0]      calc_hi, calc_lo;
   logic             calc_wr, wr_d, accept, finish;
   mdu_op_e          op_in;

   assign op_in  = mdu_op_e'(bus.op);
   assign accept = (state_q == ST_IDLE) && bus.start && (is_mult(op_in) || is_div(op_in));
   assign finish = (state_q == ST_RUN) && (cnt_q == CNT_W'(1));

   mdu_calc u_calc (
      .op_i (op_q),
      .a_i  (a_q),
      .b_i  (b_q),
      .hi_o (calc_hi),
      .lo_o (calc_lo),
      .wr_o (calc_wr)
   );

   always_comb begin
      hi_d = hi_q;
      lo_d = lo_q;
      wr_d = 1'b0;
      if (state_q == ST_IDLE && bus.start && op_in == OP_MTHI) begin
         hi_d = bus.A;
         wr_d = 1'b1;
      end else if (state_q == ST_IDLE && bus.start && op_in == OP_MTLO) begin
         lo_d = bus.A;
         wr_d = 1'b1;
      end else if (finish && calc_wr) begin
         hi_d = calc_hi;
         lo_d = calc_lo;
         wr_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         op_q    <= OP_NONE;
         a_q     <= '0;
         b_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         hi_q <= hi_d;
         lo_q <= lo_d;
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  op_q    <= op_in;
                  a_q     <= bus.A;
                  b_q     <= bus.B;
                  cnt_q   <= is_mult(op_in) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                  state_q <= ST_RUN;
               end
            end
            ST_RUN: begin
               // Counter holds the busy cycles still to run, including this one.
               if (finish) begin
                  cnt_q   <= '0;
                  state_q <= ST_IDLE;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.busy    = (state_q == ST_RUN);
   assign bus.HI      = hi_q;
   assign bus.LO      = lo_q;
   assign dbg_state_o = state_q;

`ifdef MDU_DISPLAY_EN
   logic [31:0] pc_q;
   logic [31:0] disp_pc;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)      pc_q <= '0;
      else if (accept) pc_q <= bus.pc;
   end

   // MTHI/MTLO write at issue, so their pc is the one on the bus right now.
   assign disp_pc = (state_q == ST_IDLE) ? bus.pc : pc_q;

   always @(posedge clk) begin
      if (reset && wr_d)
         $display("@%08h: HI <= %08h, LO <= %08h", disp_pc, hi_d, lo_d);
   end
`endif

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: randomized ops against an arithmetic reference
// model, with a scoreboard queue drained by a monitor on busy completion.
module tb_mdu;
  import mdu_pkg::*;

  localparam int W = 72;  // {busy cycles[7:0], HI, LO}

  logic clk = 1'b0;
  logic reset = 1'b0;
  mdu_state_e dbg_state;
  mdu_if bus();

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  logic [63:0]  model_hilo;
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  function automatic int cycles_of(input logic [2:0] op);
    if (op == 3'd1 || op == 3'd2) return 5;
    if (op == 3'd3 || op == 3'd4) return 10;
    return 0;
  endfunction

  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] cur);
    longint     p;
    logic [63:0] ua, ub;
    int sa, sb, q, r;
    sa = a;
    sb = b;
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'd1: begin p = longint'(sa) * longint'(sb); return p; end
      3'd2: return ua * ub;
      3'd3: begin
        if (b == 32'd0) return cur;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = sa / sb;
        r = sa % sb;
        return {32'(r), 32'(q)};
      end
      3'd4: begin
        if (b == 32'd0) return cur;
        return {a % b, a / b};
      end
      3'd5: return {a, cur[31:0]};
      3'd6: return {cur[63:32], a};
      default: return cur;
    endcase
  endfunction

  // ---------------- driver ----------------
  // Issues one op from IDLE; optionally keeps start high with another op for
  // the whole busy window, including the edge where busy falls.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic hold, input logic [2:0] iop, input logic [31:0] ia);
    logic [63:0] nxt;
    int n, waited;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.A     = a;
    bus.B     = b;
    bus.pc    = $urandom;
    nxt = model(op, a, b, model_hilo);
    n   = cycles_of(op);
    if (n > 0) exp_q.push_back({8'(n), nxt});
    @(posedge clk);
    #1;
    if (n > 0 && hold) begin
      bus.op = iop;
      bus.A  = ia;
      bus.B  = $urandom;
    end else begin
      bus.start = 1'b0;
    end
    model_hilo = nxt;
    if (n == 0) begin
      chk("imm_hi", bus.HI, nxt[63:32]);
      chk("imm_lo", bus.LO, nxt[31:0]);
      chk("imm_busy", {31'd0, bus.busy}, 32'd0);
    end else begin
      waited = 0;
      while (bus.busy && waited < 64) begin
        @(negedge clk);
        waited++;
      end
      bus.start = 1'b0;
      chk("done_in_time", {31'd0, bus.busy}, 32'd0);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    int bcnt;
    logic was_busy;
    logic [W-1:0] e;
    bcnt = 0;
    was_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        bcnt = 0;
        was_busy = 1'b0;
      end else if (bus.busy) begin
        bcnt++;
        was_busy = 1'b1;
      end else if (was_busy) begin
        was_busy = 1'b0;
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("busy_len", 32'(bcnt), {24'd0, e[71:64]});
          chk("res_hi", bus.HI, e[63:32]);
          chk("res_lo", bus.LO, e[31:0]);
        end
        bcnt = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    logic [2:0]  rop, iop;
    logic [31:0] ra, rb;
    bus.start = 1'b0;
    bus.op    = 3'd0;
    bus.A     = '0;
    bus.B     = '0;
    bus.pc    = '0;
    model_hilo = '0;

    repeat (3) @(posedge clk);
    #2;
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_hi", bus.HI, 32'd0);
    chk("rst_lo", bus.LO, 32'd0);
    #1 reset = 1'b1;

    // Directed cases with hand-derived results.
    run_op(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, 3'd0, 32'd0);
    chk("mult_hi", bus.HI, 32'hFFFF_FFFF);
    chk("mult_lo", bus.LO, 32'hFFFF_FFFA);
    run_op(3'd2, 32'hFFFF_FFFE, 32'd3, 1'b0, 3'd0, 32'd0);
    chk("multu_hi", bus.HI, 32'h0000_0002);
    chk("multu_lo", bus.LO, 32'hFFFF_FFFA);
    run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 3'd0, 32'd0);
    chk("div_hi", bus.HI, 32'hFFFF_FFFF);
    chk("div_lo", bus.LO, 32'hFFFF_FFFD);
    run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 3'd0, 32'd0);
    chk("div_ovf_hi", bus.HI, 32'h0000_0000);
    chk("div_ovf_lo", bus.LO, 32'h8000_0000);
    run_op(3'd5, 32'h1234_5678, 32'd0, 1'b0, 3'd0, 32'd0);
    run_op(3'd4, 32'd7, 32'd0, 1'b0, 3'd0, 32'd0);
    chk("divu0_hi", bus.HI, 32'h1234_5678);
    chk("divu0_lo", bus.LO, 32'h8000_0000);
    run_op(3'd6, 32'hCAFE_F00D, 32'd0, 1'b0, 3'd0, 32'd0);
    run_op(3'd0, 32'hDEAD_BEEF, 32'd1, 1'b0, 3'd0, 32'd0);
    run_op(3'd7, 32'hDEAD_BEEF, 32'd1, 1'b0, 3'd0, 32'd0);
    // Held MTHI across the falling-busy edge must be dropped.
    run_op(3'd2, 32'd9, 32'd9, 1'b1, 3'd5, 32'h5555_5555);
    chk("b2b_hi", bus.HI, 32'd0);

    // Randomized traffic with ignored starts during busy.
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      rb  = ($urandom_range(0, 5) == 0) ? 32'd0 :
            ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : $urandom;
      iop = 3'($urandom_range(0, 7));
      run_op(rop, ra, rb, 1'($urandom_range(0, 1)), iop, $urandom);
    end

    // DIV aborted by reset in its 4th busy cycle, MTLO held meanwhile.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 3'd3;
    bus.A     = $urandom;
    bus.B     = 32'd3;
    @(posedge clk);
    #1;
    bus.op = 3'd6;
    bus.A  = 32'hAAAA_5555;
    repeat (3) @(posedge clk);
    #1;
    chk("mtlo_ignored", bus.LO, model_hilo[31:0]);
    #1 reset = 1'b0;
    #1;
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_hi", bus.HI, 32'd0);
    chk("abort_lo", bus.LO, 32'd0);
    bus.start  = 1'b0;
    model_hilo = '0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    run_op(3'd5, 32'h5A5A_A5A5, 32'd0, 1'b0, 3'd0, 32'd0);
    repeat (15) @(posedge clk);
    #1;
    chk("no_late_hi", bus.HI, 32'h5A5A_A5A5);
    chk("no_late_lo", bus.LO, 32'd0);

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 Parameter MULT_CYCLES, default 5, busy duration in cycles of MULT/MULTU (legal 1..15).
REQ-002 Parameter DIV_CYCLES, default 10, busy duration in cycles of DIV/DIVU (legal 1..15).
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  operation request, qualified with op.
REQ-006 op  input  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE).
REQ-007 A  input  32  rs read data from register file (dividend / multiplicand / MT source).
REQ-008 B  input  32  rt read data from register file (divisor / multiplier).
REQ-009 pc  input  32  PC of issuing instruction; used only under MDU_DISPLAY_EN.
REQ-010 busy  output  1  high while a multiply/divide is in flight.
REQ-011 HI  output  32  architectural HI register.
REQ-012 LO  output  32  architectural LO register.

Function
REQ-013 States: IDLE, RUN; busy SHALL be high exactly in RUN.
REQ-014 In IDLE, start=1 with op MULT/MULTU/DIV/DIVU at edge k SHALL latch op, A, B, pc, load counter with MULT_CYCLES or DIV_CYCLES, and enter RUN.
REQ-015 busy SHALL be high for exactly N cycles following edge k (N per REQ-014); at edge k+N state returns to IDLE and HI/LO update on that same edge.
REQ-016 HI/LO SHALL hold their old values throughout RUN; no intermediate value is visible.
REQ-017 start with any op while in RUN SHALL be ignored (no latch, no HI/LO change, counter unaffected).
REQ-018 In IDLE, start with MTHI SHALL write HI<=A at that edge; MTLO SHALL write LO<=A; busy stays low.
REQ-019 start with NONE or reserved op SHALL have no effect.
REQ-020 MULT: {HI,LO} = signed 64-bit product of latched A and B; MULTU: unsigned 64-bit product.
REQ-021 DIV: LO = signed quotient truncated toward zero, HI = remainder with dividend's sign; DIVU: unsigned quotient/remainder.
REQ-022 DIV 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0x00000000.
REQ-023 Divisor zero (DIV or DIVU): full DIV_CYCLES busy still occurs; HI and LO SHALL be left unchanged.
REQ-024 Back-to-back: start at edge k+N (busy falling) SHALL be ignored; a new op is accepted at the first edge where busy was low before the edge.

Reset
REQ-025 reset low SHALL immediately force state IDLE, busy=0, HI=0, LO=0, counter=0, latched operands=0, independent of clk.
REQ-026 reset asserted mid-RUN SHALL abort the operation; no result is ever written after release.
REQ-027 First start is honoured at the first posedge clk after reset returns high.

Configuration
REQ-028 Macro MDU_DISPLAY_EN: when defined, every HI/LO write (REQ-015, REQ-018) SHALL print "@<pc>: HI <= <hi>, LO <= <lo>" (8-digit hex, latched pc, post-write values); when undefined, no print is compiled and pc is unused.

Structure
REQ-029 Package mdu_pkg SHALL hold the op encodings, the IDLE/RUN state typedef, and the 4-bit counter width constant.
REQ-030 One sub-module, mdu_calc, SHALL be the combinational 64-bit product/quotient/remainder unit fed by latched operands; mdu holds FSM, counter and HI/LO.

Verification
REQ-031 MULT A=0xFFFFFFFE, B=3 -> busy 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-032 MULTU A=0xFFFFFFFE, B=3 -> HI=0x00000002, LO=0xFFFFFFFA after 5 busy cycles.
REQ-033 DIV A=0xFFFFFFF9, B=2 -> busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-034 MTHI A=0x12345678 then DIVU A=7, B=0 -> HI=0x12345678 immediately, busy 10 cycles, HI/LO unchanged after.
REQ-035 DIV started, MTLO A=0xAAAA5555 issued during busy -> LO unaffected; reset low at busy cycle 4 -> busy=0, HI=LO=0 without clock edge.
REQ-036 Under MDU_DISPLAY_EN, MULT at pc=0x00003004 with A=2, B=3 -> exactly one line "@00003004: HI <= 00000000, LO <= 00000006".
